// File: rtl/sitcp_tx_mux.sv
// Multi-channel SiTCP transmit multiplexer: per-channel FWFT byte FIFOs, round-robin
// arbitration and framed bursts ({4'hA,ch}, len-1, payload) onto the TCP_TX byte stream.
module sitcp_tx_mux #(
    parameter int NCH          = 4,
    parameter int DEPTH_LOG2   = 11,
    parameter int AFULL_MARGIN = 64,
    parameter int MAX_BURST    = 256
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NCH*8-1:0] CH_DATA,
    input  logic [NCH-1:0]   CH_WR,
    output logic [NCH-1:0]   CH_FULL,
    output logic [NCH-1:0]   CH_OVF,
    input  logic             TCP_OPEN_ACK,
    input  logic             SOFT_RESET,
    input  logic             TCP_TX_FULL,
    output logic             TCP_TX_WR,
    output logic [7:0]       TCP_TX_DATA,
    output logic             BUSY
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_THR = CW'(DEPTH - AFULL_MARGIN);

    typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;

    state_t         state_q;
    logic [CHW-1:0] ch_q;
    logic [CHW-1:0] rr_q;
    logic [8:0]     len_q;
    logic [8:0]     rem_q;
    logic           tx_wr_q;
    logic [7:0]     tx_data_q;

    logic           flush;
    logic           pop_en;
    logic [CW-1:0]  count [NCH];
    logic [7:0]     head  [NCH];
    logic [NCH-1:0] pop;

    assign flush  = !TCP_OPEN_ACK || SOFT_RESET;
    assign pop_en = (state_q == DATA) && !TCP_TX_FULL && !flush && !RST;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [7:0]            mem [DEPTH];
            logic [DEPTH_LOG2-1:0] wr_ptr_q;
            logic [DEPTH_LOG2-1:0] rd_ptr_q;
            logic [CW-1:0]         count_q;
            logic [CW-1:0]         count_d;
            logic                  full_q;
            logic                  ovf_q;
            logic                  wr_acc;

            // A write into a completely full FIFO is dropped even if a pop frees a slot this edge.
            assign wr_acc  = CH_WR[gi] && (count_q != DEPTH_C);
            assign pop[gi] = pop_en && (ch_q == CHW'(gi));
            assign count_d = count_q + CW'(wr_acc) - CW'(pop[gi]);

            always_ff @(posedge CLK) begin
                if (wr_acc) begin
                    mem[wr_ptr_q] <= CH_DATA[8*gi +: 8];
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                    full_q   <= 1'b0;
                    ovf_q    <= 1'b0;
                end else if (flush) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                    full_q   <= 1'b0;
                end else begin
                    if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (pop[gi]) rd_ptr_q <= rd_ptr_q + 1'b1;
                    if (CH_WR[gi] && !wr_acc) ovf_q <= 1'b1;
                    count_q <= count_d;
                    full_q  <= (count_q >= FULL_THR);
                end
            end

            assign count[gi]   = count_q;
            assign head[gi]    = mem[rd_ptr_q];
            assign CH_FULL[gi] = full_q;
            assign CH_OVF[gi]  = ovf_q;
        end
    endgenerate

    // Round-robin search starting at rr_q; first non-empty channel wins.
    logic           grant_found;
    logic [CHW-1:0] grant_ch;
    logic [8:0]     grant_len;
    logic [CW-1:0]  grant_cnt;
    int             arb_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        arb_idx     = 0;
        for (int i = 0; i < NCH; i++) begin
            arb_idx = int'(rr_q) + i;
            if (arb_idx >= NCH) arb_idx = arb_idx - NCH;
            if (!grant_found && count[CHW'(arb_idx)] != '0) begin
                grant_found = 1'b1;
                grant_ch    = CHW'(arb_idx);
            end
        end
        grant_cnt = count[grant_ch];
        grant_len = (int'(grant_cnt) > MAX_BURST) ? 9'(MAX_BURST) : 9'(grant_cnt);
    end

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            rr_q      <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_wr_q <= 1'b0;
                    if (grant_found) begin
                        ch_q    <= grant_ch;
                        len_q   <= grant_len;
                        state_q <= HDR0;
                    end
                end
                HDR0: begin
                    tx_wr_q <= !TCP_TX_FULL;
                    if (!TCP_TX_FULL) begin
                        tx_data_q <= {4'hA, 4'(ch_q)};
                        state_q   <= HDR1;
                    end
                end
                HDR1: begin
                    tx_wr_q <= !TCP_TX_FULL;
                    if (!TCP_TX_FULL) begin
                        tx_data_q <= 8'(len_q - 9'd1);
                        rem_q     <= len_q;
                        state_q   <= DATA;
                    end
                end
                default: begin
                    tx_wr_q <= !TCP_TX_FULL;
                    if (!TCP_TX_FULL) begin
                        tx_data_q <= head[ch_q];
                        rem_q     <= rem_q - 9'd1;
                        if (rem_q == 9'd1) begin
                            state_q <= IDLE;
                            rr_q    <= (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign TCP_TX_WR   = tx_wr_q;
    assign TCP_TX_DATA = tx_data_q;
    assign BUSY        = (state_q != IDLE);
endmodule

// File: doc/sitcp_tx_mux.md
Name: sitcp_tx_mux

Overview:
- Multi-channel successor to the single-FIFO TCP transmit path that sits between user data sources and the SiTCP TCP_TX_* interface.
- Buffers NCH independent byte streams in per-channel FIFOs.
- Arbitrates between channels round-robin and emits framed bursts (2-byte header + payload) into one TCP byte stream.
- Honours TCP_TX_FULL back-pressure, and flushes on connection loss or soft reset.

Parameters:
- NCH, 4: number of input channels; range 1..16.
- DEPTH_LOG2, 11: per-channel FIFO depth = 2**DEPTH_LOG2 bytes.
- AFULL_MARGIN, 64: CH_FULL asserts when fill count >= 2**DEPTH_LOG2 - AFULL_MARGIN.
- MAX_BURST, 256: maximum payload bytes per frame; range 1..256.

Ports:
- CLK  in  1  system clock (200 MHz domain, same as SiTCP CLK).
- RST  in  1  synchronous reset, active-high.
- CH_DATA  in  NCH*8  channel byte data; channel k occupies bits [8k+7:8k].
- CH_WR  in  NCH  per-channel write strobe.
- CH_FULL  out  NCH  per-channel almost-full (prog-full).
- CH_OVF  out  NCH  sticky overflow flag: a write was dropped.
- TCP_OPEN_ACK  in  1  SiTCP connection established.
- SOFT_RESET  in  1  user flush request.
- TCP_TX_FULL  in  1  SiTCP TX almost-full.
- TCP_TX_WR  out  1  byte valid to SiTCP.
- TCP_TX_DATA  out  8  byte to SiTCP.
- BUSY  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset values (RST=1 at a clock edge):
  - All FIFO pointers and counts 0; CH_FULL=0; CH_OVF=0.
  - TCP_TX_WR=0; TCP_TX_DATA=0x00; BUSY=0.
  - FSM in IDLE; round-robin pointer=0.
- Flush (TCP_OPEN_ACK=0 or SOFT_RESET=1, sampled at an edge):
  - Same effect as RST, except CH_OVF is preserved.
  - Takes effect even mid-burst; the frame is truncated with no padding.
  - Writes in a flush cycle are discarded and do not set CH_OVF.
- FIFO:
  - First-word-fall-through; head byte is readable combinationally.
  - Write with count = 2**DEPTH_LOG2 is dropped and sets CH_OVF[k], even if a read happens on the same edge.
  - Simultaneous read and write on a non-full FIFO leaves count unchanged.
  - Pointers wrap modulo depth.
  - CH_FULL is registered and follows count with 1-cycle latency.
- Arbitration (IDLE only):
  - A channel is eligible if count >= 1.
  - Search starts at (last_grant+1) mod NCH, first eligible wins.
  - On grant: latch ch, latch len = min(count, MAX_BURST), go to HDR0.
  - No eligible channel: stay in IDLE.
  - Data written while a grant is being evaluated is not counted in len.
- FSM: IDLE -> HDR0 -> HDR1 -> DATA -> IDLE.
  - HDR0 byte = {4'hA, ch[3:0]}.
  - HDR1 byte = len-1 (8 bits).
  - DATA: pops one byte per emitted cycle; after the len-th byte, go to IDLE and set last_grant=ch.
- Output handshake:
  - TCP_TX_WR and TCP_TX_DATA are registered.
  - In HDR0, HDR1 or DATA, if TCP_TX_FULL=0 at an edge, that state's byte is loaded, TCP_TX_WR=1 for the following cycle, and the FSM advances or the pop occurs.
  - If TCP_TX_FULL=1: TCP_TX_WR=0 and the state is held; no byte is lost or duplicated.
  - In IDLE, TCP_TX_WR=0.
- Latency:
  - Byte written to an empty FIFO at edge e0, with an idle FSM and TCP_TX_FULL=0.
  - HDR0 is on the bus after e2; payload byte 1 is on the bus after e4.
  - Sustained throughput is 1 byte/cycle inside a frame, with 3 overhead cycles per frame (IDLE + 2 headers).
- Priority of simultaneous events: RST > flush > normal operation.

Test Plan:
1. Single byte: write 0x5C on ch2, idle bus, TCP_TX_FULL=0 -> TCP_TX_WR pulses 3 consecutive cycles with bytes A2, 00, 5C; first beat 2 cycles after the write edge; BUSY falls after the last beat.
2. Round-robin: preload ch0=3 bytes, ch1=1, ch3=2 -> frames in order ch0 (A0 02 …), ch1 (A1 00 …), ch3 (A3 01 …); then preload ch0 and ch1 again -> ch0 then ch1, since the pointer wraps past ch3.
3. Burst cap: 300 bytes incrementing 0..299 on ch1 -> frame A1 FF + bytes 0..255, then frame A1 2B + bytes 256..299.
4. Back-pressure: hold TCP_TX_FULL=1 for 5 cycles at arbitrary points inside a 10-byte frame -> TCP_TX_WR=0 during the stall; the byte sequence is exactly the 2 headers + 10 bytes with no gap errors, loss or duplication.
5. Overflow: write 2**DEPTH_LOG2+3 bytes to ch0 while TCP_TX_FULL=1 -> CH_FULL[0] asserts at count 1984; CH_OVF[0]=1; exactly 2048 bytes are later emitted.
6. Flush mid-burst: deassert TCP_OPEN_ACK during the DATA state of a 20-byte frame -> next cycle TCP_TX_WR=0, BUSY=0, all counts 0, CH_OVF retained; a later write after TCP_OPEN_ACK=1 produces a fresh frame starting at HDR0.
